fetch_sequencer: RTL

//  Instruction-fetch controller that sequences the 16-bit program counter.
//  - Issues fetches to instruction memory at the current PC over a req/ack handshake.
//  - Hands each fetched word to decode over a valid/ready handshake.
//  - Decodes jump/branch/halt and drives the PC's 2-bit control plus target addresses.
//  - Sits between the PC register, instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: fetches at the PC, hands words to decode, and steers the PC on jump/branch/halt.
// Optional fetch watchdog with a sticky FAULT state is built when FETCH_TIMEOUT_EN is defined.
module fetch_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int INSTR_W        = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic [1:0]         pc_control,
  output logic [ADDR_W-1:0]  branch_address,
  output logic [ADDR_W-1:0]  jump_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               cond_flag,
  input  logic               resume,
  output logic               halted,
  output logic               fetch_fault,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t state, state_next;

  logic [3:0] opcode;
  logic       is_jmp, is_brz, is_halt, accept, timeout_hit;

  // Handshakes: imem_req/imem_addr stay stable until the single-cycle imem_ack;
  // a decode transfer happens only in a cycle where instr_valid and instr_ready are both high.
  assign opcode  = instr_out[INSTR_W-1:INSTR_W-4];
  assign is_jmp  = (opcode == 4'hF);
  assign is_brz  = (opcode == 4'hE);
  assign is_halt = (instr_out == '0);
  assign accept  = (state == S_ISSUE) && instr_ready;

  // Targets are derived from the held word, so they read 0 straight out of reset.
  assign jump_address   = {instr_pc[ADDR_W-1:12], instr_out[11:0]};
  assign branch_address = instr_pc + {{(ADDR_W-8){instr_out[7]}}, instr_out[7:0]};

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  assign timeout_hit = (state == S_FETCH) && !imem_ack &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != S_FETCH || imem_ack) begin
      wd_cnt <= '0;
    end else if (!timeout_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_next = S_ISSUE;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_next = is_halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  begin
        if (resume) begin
          state_next = S_FETCH;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_control = 2'b00;
    if (accept) begin
      if (is_jmp) begin
        pc_control = 2'b11;
      end else if (is_brz) begin
        pc_control = cond_flag ? 2'b10 : 2'b01;
      end else if (is_halt) begin
        pc_control = 2'b00;
      end else begin
        pc_control = 2'b01;
      end
    end else if (state == S_HALT && resume) begin
      pc_control = 2'b01;
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = (state == S_FETCH) ? pc_value : '0;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign fetch_fault = (state == S_FAULT);
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_out <= '0;
      instr_pc  <= '0;
    end else if (state == S_FETCH && imem_ack) begin
      instr_out <= imem_rdata;
      instr_pc  <= pc_value;
    end
  end

endmodule
